// File: rtl/ram8x32_rr_port_arbiter_pkg.sv
// Shared types and defaults for the RAM8x32 round-robin port arbiter.
package ram8x32_rr_port_arbiter_pkg;

  localparam int unsigned DefAw = 3;
  localparam int unsigned DefDw = 32;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  // Number of byte lanes for a given data width.
  function automatic int unsigned num_bytes(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ram8x32_rr_port_arbiter_arb2.sv
// Two-way round-robin grant with a single-bit priority pointer.
module ram8x32_rr_port_arbiter_arb2 (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  // Sole requester always wins; on contention the pointer picks the winner.
  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

  // Last winner drops to low priority; no grant leaves the pointer alone.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = 1'b1;
    end else if (gnt_o[1]) begin
      ptr_d = 1'b0;
    end
  end

  // Pointer register, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram8x32_rr_port_arbiter.sv
// Shares one single-port RAM8x32 macro between two requesters: clears the array after
// reset, then arbitrates round-robin with one access per cycle and a 1-cycle response.
module ram8x32_rr_port_arbiter
  import ram8x32_rr_port_arbiter_pkg::*;
#(
  parameter int unsigned   AW         = DefAw,
  parameter int unsigned   DW         = DefDw,
  parameter bit            INIT_EN    = 1'b1,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   R0_VALID,
  output logic                   R0_READY,
  input  logic [DW/8-1:0]        R0_WE,
  input  logic [AW-1:0]          R0_A,
  input  logic [DW-1:0]          R0_DI,
  output logic                   R0_RVALID,
  output logic [DW-1:0]          R0_RDATA,
  input  logic                   R1_VALID,
  output logic                   R1_READY,
  input  logic [DW/8-1:0]        R1_WE,
  input  logic [AW-1:0]          R1_A,
  input  logic [DW-1:0]          R1_DI,
  output logic                   R1_RVALID,
  output logic [DW-1:0]          R1_RDATA,
  output logic                   BUSY_INIT,
  output logic                   RAM_EN,
  output logic [DW/8-1:0]        RAM_WE,
  output logic [AW-1:0]          RAM_A,
  output logic [DW-1:0]          RAM_DI,
  input  logic [DW-1:0]          RAM_DO
);

  localparam int unsigned NB = num_bytes(DW);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic [1:0]    tag_q;
  logic [AW-1:0] a_q;
  logic [DW-1:0] di_q;
  logic          run;
  logic [1:0]    req;
  logic [1:0]    gnt;

  // Grants only exist in RUN and never while reset is asserted.
  assign run = RST_N && (state_q == StRun);
  assign req = {R1_VALID, R0_VALID} & {2{run}};

  ram8x32_rr_port_arbiter_arb2 u_arb (
    .CLK   (CLK),
    .RST_N (RST_N),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign R0_READY  = gnt[0];
  assign R1_READY  = gnt[1];
  assign BUSY_INIT = busy_q;

  // Clear-sequence FSM: walk every word once, then stay in RUN until reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= INIT_EN ? StInit : StRun;
      cnt_q   <= '0;
      busy_q  <= INIT_EN;
    end else if (state_q == StInit) begin
      if (cnt_q == '1) begin
        state_q <= StRun;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_q + AW'(1);
      end
    end
  end

  // Macro mux: INIT pattern, else the granted requester; idle keeps A/DI steady.
  always_comb begin
    RAM_EN = 1'b0;
    RAM_WE = '0;
    RAM_A  = a_q;
    RAM_DI = di_q;
    if (RST_N) begin
      if (state_q == StInit) begin
        RAM_EN = 1'b1;
        RAM_WE = {NB{1'b1}};
        RAM_A  = cnt_q;
        RAM_DI = INIT_VALUE;
      end else if (gnt[0]) begin
        RAM_EN = 1'b1;
        RAM_WE = R0_WE;
        RAM_A  = R0_A;
        RAM_DI = R0_DI;
      end else if (gnt[1]) begin
        RAM_EN = 1'b1;
        RAM_WE = R1_WE;
        RAM_A  = R1_A;
        RAM_DI = R1_DI;
      end
    end
  end

  // Remember the last driven address/data so idle cycles do not toggle the macro pins.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      a_q  <= '0;
      di_q <= '0;
    end else if (RAM_EN) begin
      a_q  <= RAM_A;
      di_q <= RAM_DI;
    end
  end

  // Response tag: which requester owns the macro output on the next cycle.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tag_q <= 2'b00;
    end else begin
      tag_q <= gnt;
    end
  end

  assign R0_RVALID = tag_q[0];
  assign R1_RVALID = tag_q[1];
  assign R0_RDATA  = RAM_DO;
  assign R1_RDATA  = RAM_DO;

endmodule

// File: tb/tb_ram8x32_rr_port_arbiter.sv
// Directed and random bench for ram8x32_rr_port_arbiter with a behavioural macro.
module tb_ram8x32_rr_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        R0_VALID, R0_READY, R0_RVALID;
  logic [3:0]  R0_WE;
  logic [2:0]  R0_A;
  logic [31:0] R0_DI, R0_RDATA;
  logic        R1_VALID, R1_READY, R1_RVALID;
  logic [3:0]  R1_WE;
  logic [2:0]  R1_A;
  logic [31:0] R1_DI, R1_RDATA;
  logic        BUSY_INIT, RAM_EN;
  logic [3:0]  RAM_WE;
  logic [2:0]  RAM_A;
  logic [31:0] RAM_DI, RAM_DO;

  int checks = 0;
  int errors = 0;
  logic [31:0] gold [8];

  always #5 CLK = ~CLK;

  ram8x32_rr_port_arbiter dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .R0_VALID  (R0_VALID),
    .R0_READY  (R0_READY),
    .R0_WE     (R0_WE),
    .R0_A      (R0_A),
    .R0_DI     (R0_DI),
    .R0_RVALID (R0_RVALID),
    .R0_RDATA  (R0_RDATA),
    .R1_VALID  (R1_VALID),
    .R1_READY  (R1_READY),
    .R1_WE     (R1_WE),
    .R1_A      (R1_A),
    .R1_DI     (R1_DI),
    .R1_RVALID (R1_RVALID),
    .R1_RDATA  (R1_RDATA),
    .BUSY_INIT (BUSY_INIT),
    .RAM_EN    (RAM_EN),
    .RAM_WE    (RAM_WE),
    .RAM_A     (RAM_A),
    .RAM_DI    (RAM_DI),
    .RAM_DO    (RAM_DO)
  );

  // Behavioural RAM8x32 macro: registered read-before-write output, byte-lane writes.
  logic [31:0] mem [8];
  always @(posedge CLK) begin
    if (RAM_EN) begin
      RAM_DO <= mem[RAM_A];
      for (int b = 0; b < 4; b++) begin
        if (RAM_WE[b]) mem[RAM_A][b*8 +: 8] <= RAM_DI[b*8 +: 8];
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (we[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  // Drive one cycle of requests, predict accepts and responses, advance past the edge.
  task automatic step(input logic v0, input logic [3:0] we0, input logic [2:0] a0,
                      input logic [31:0] d0, input logic v1, input logic [3:0] we1,
                      input logic [2:0] a1, input logic [31:0] d1,
                      output logic g0, output logic g1, output logic [31:0] e0,
                      output logic [31:0] e1, output logic en);
    R0_VALID = v0; R0_WE = we0; R0_A = a0; R0_DI = d0;
    R1_VALID = v1; R1_WE = we1; R1_A = a1; R1_DI = d1;
    #1;
    g0 = v0 & R0_READY;
    g1 = v1 & R1_READY;
    en = RAM_EN;
    e0 = gold[a0];
    e1 = gold[a1];
    if (g0) gold[a0] = merge(gold[a0], we0, d0);
    if (g1) gold[a1] = merge(gold[a1], we1, d1);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic g0, g1, en;
    logic [31:0] e0, e1;
    int busy_cycles;
    RST_N = 1'b0;
    R0_VALID = 1'b1; R0_WE = 4'h0; R0_A = 3'd0; R0_DI = '0;
    R1_VALID = 1'b1; R1_WE = 4'h0; R1_A = 3'd1; R1_DI = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (R0_READY !== 1'b0 || R1_READY !== 1'b0) begin errors++;
      $display("FAIL reset_ready: got %b%b want 00", R1_READY, R0_READY); end
    checks++; if (RAM_EN !== 1'b0) begin errors++;
      $display("FAIL reset_ram_en: got %b want 0", RAM_EN); end
    checks++; if (R0_RVALID !== 1'b0 || R1_RVALID !== 1'b0) begin errors++;
      $display("FAIL reset_rvalid: got %b%b want 00", R1_RVALID, R0_RVALID); end
    checks++; if (BUSY_INIT !== 1'b1) begin errors++;
      $display("FAIL reset_busy: got %b want 1", BUSY_INIT); end
    RST_N = 1'b1;
    #1;
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (BUSY_INIT === 1'b1) busy_cycles++;
      checks++;
      if (RAM_EN !== 1'b1 || RAM_WE !== 4'hF || RAM_A !== 3'(i) || RAM_DI !== 32'h0) begin
        errors++;
        $display("FAIL init_drive[%0d]: got en=%b we=%h a=%0d di=%h want 1 f %0d 0", i,
                 RAM_EN, RAM_WE, RAM_A, RAM_DI, i);
      end
      checks++; if (R0_READY !== 1'b0 || R1_READY !== 1'b0) begin errors++;
        $display("FAIL init_ready[%0d]: got %b%b want 00", i, R1_READY, R0_READY); end
      @(posedge CLK);
      #1;
    end
    checks++; if (busy_cycles != 8 || BUSY_INIT !== 1'b0) begin errors++;
      $display("FAIL init_busy_len: got %0d cycles, busy now %b want 8, 0", busy_cycles,
               BUSY_INIT); end
    for (int i = 0; i < 8; i++) gold[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'h0, 3'(i), 32'h0, 1'b0, 4'h0, 3'd0, 32'h0, g0, g1, e0, e1, en);
      checks++; if (R0_RVALID !== 1'b1 || R0_RDATA !== 32'h0) begin errors++;
        $display("FAIL init_readback[%0d]: got v=%b d=%h want 1 0", i, R0_RVALID, R0_RDATA);
      end
    end
  endtask

  task automatic test_write_read();
    logic g0, g1, en;
    logic [31:0] e0, e1;
    step(1'b1, 4'hF, 3'd3, 32'hDEADBEEF, 1'b0, 4'h0, 3'd0, 32'h0, g0, g1, e0, e1, en);
    checks++; if (R0_RVALID !== 1'b1 || R0_RDATA !== 32'h0) begin errors++;
      $display("FAIL wr_resp: got v=%b d=%h want 1 0", R0_RVALID, R0_RDATA); end
    step(1'b1, 4'h0, 3'd3, 32'h0, 1'b0, 4'h0, 3'd0, 32'h0, g0, g1, e0, e1, en);
    checks++; if (R0_RVALID !== 1'b1 || R0_RDATA !== 32'hDEADBEEF) begin errors++;
      $display("FAIL rd_resp: got v=%b d=%h want 1 deadbeef", R0_RVALID, R0_RDATA); end
    R0_VALID = 1'b0; R1_VALID = 1'b0;
    #1;
    checks++; if (RAM_EN !== 1'b0 || RAM_WE !== 4'h0 || RAM_A !== 3'd3) begin errors++;
      $display("FAIL idle_hold: got en=%b we=%h a=%0d want 0 0 3", RAM_EN, RAM_WE, RAM_A); end
    @(posedge CLK);
    #1;
    checks++; if (R0_RVALID !== 1'b0 || R1_RVALID !== 1'b0) begin errors++;
      $display("FAIL rvalid_one_cycle: got %b%b want 00", R1_RVALID, R0_RVALID); end
  endtask

  task automatic test_alternate();
    logic g0, g1, en;
    logic [31:0] e0, e1;
    // R1-only access leaves the pointer favouring requester 0.
    step(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 4'h0, 3'd5, 32'h0, g0, g1, e0, e1, en);
    checks++; if (R1_RVALID !== 1'b1 || R0_RVALID !== 1'b0 || R1_RDATA !== 32'h0) begin
      errors++;
      $display("FAIL r1_solo: got v=%b%b d=%h want 10 0", R1_RVALID, R0_RVALID, R1_RDATA);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'h0, 3'd3, 32'h0, 1'b1, 4'h0, 3'd5, 32'h0, g0, g1, e0, e1, en);
      checks++; if (g0 !== (i % 2 == 0) || g1 !== (i % 2 == 1) || en !== 1'b1) begin
        errors++;
        $display("FAIL alt_grant[%0d]: got g=%b%b en=%b want %0d", i, g1, g0, en, i % 2);
      end
      checks++;
      if (R0_RVALID !== g0 || R1_RVALID !== g1 ||
          (g0 && R0_RDATA !== 32'hDEADBEEF) || (g1 && R1_RDATA !== 32'h0)) begin
        errors++;
        $display("FAIL alt_resp[%0d]: got v=%b%b d=%h", i, R1_RVALID, R0_RVALID, R0_RDATA);
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic g0, g1, en;
    logic [31:0] e0, e1;
    step(1'b1, 4'hF, 3'd5, 32'hFFFFFFFF, 1'b0, 4'h0, 3'd0, 32'h0, g0, g1, e0, e1, en);
    step(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 4'b0010, 3'd5, 32'h0000AB00, g0, g1, e0, e1, en);
    checks++; if (R1_RVALID !== 1'b1 || R1_RDATA !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL byte_wr_resp: got v=%b d=%h want 1 ffffffff", R1_RVALID, R1_RDATA); end
    step(1'b1, 4'b1100, 3'd5, 32'h12340000, 1'b0, 4'h0, 3'd0, 32'h0, g0, g1, e0, e1, en);
    checks++; if (R0_RVALID !== 1'b1 || R0_RDATA !== 32'hFFFFABFF) begin errors++;
      $display("FAIL half_wr_resp: got v=%b d=%h want 1 ffffabff", R0_RVALID, R0_RDATA); end
    step(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 4'h0, 3'd5, 32'h0, g0, g1, e0, e1, en);
    checks++; if (R1_RVALID !== 1'b1 || R1_RDATA !== 32'h1234ABFF) begin errors++;
      $display("FAIL lane_read: got v=%b d=%h want 1 1234abff", R1_RVALID, R1_RDATA); end
  endtask

  task automatic test_reset_inflight();
    logic g0, g1, en;
    logic [31:0] e0, e1;
    step(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 4'h0, 3'd3, 32'h0, g0, g1, e0, e1, en);
    checks++; if (R1_RVALID !== 1'b1 || R1_RDATA !== 32'hDEADBEEF) begin errors++;
      $display("FAIL inflight_resp: got v=%b d=%h want 1 deadbeef", R1_RVALID, R1_RDATA); end
    RST_N = 1'b0;
    R0_VALID = 1'b1; R0_WE = 4'hF; R0_A = 3'd6; R0_DI = 32'h55555555;
    #1;
    checks++; if (RAM_EN !== 1'b0 || R0_READY !== 1'b0 || R1_READY !== 1'b0) begin errors++;
      $display("FAIL rst_mid_gate: got en=%b rdy=%b%b want 0 00", RAM_EN, R1_READY, R0_READY);
    end
    @(posedge CLK);
    #1;
    checks++; if (R1_RVALID !== 1'b0 || BUSY_INIT !== 1'b1) begin errors++;
      $display("FAIL rst_mid_drop: got rvalid=%b busy=%b want 0 1", R1_RVALID, BUSY_INIT); end
    RST_N = 1'b1;
    R0_VALID = 1'b0; R1_VALID = 1'b0;
    repeat (8) @(posedge CLK);
    #1;
    checks++; if (BUSY_INIT !== 1'b0) begin errors++;
      $display("FAIL rst_mid_busy_end: got %b want 0", BUSY_INIT); end
    for (int i = 0; i < 8; i++) gold[i] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 4'h0, 3'(i), 32'h0, g0, g1, e0, e1, en);
      checks++; if (R1_RVALID !== 1'b1 || R1_RDATA !== 32'h0) begin errors++;
        $display("FAIL rst_mid_readback[%0d]: got v=%b d=%h want 1 0", i, R1_RVALID,
                 R1_RDATA); end
    end
  endtask

  task automatic test_random();
    logic g0, g1, en;
    logic [31:0] e0, e1;
    logic v0, v1;
    logic [3:0] w0, w1;
    logic [2:0] a0, a1;
    logic [31:0] d0, d1;
    int wait0, wait1;
    v0 = 1'b0; v1 = 1'b0; wait0 = 0; wait1 = 0;
    w0 = '0; w1 = '0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!v0) begin
        v0 = ($urandom_range(3) != 0);
        w0 = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
        a0 = 3'($urandom); d0 = $urandom;
      end
      if (!v1) begin
        v1 = ($urandom_range(3) != 0);
        w1 = ($urandom_range(1) == 1) ? 4'($urandom) : 4'h0;
        a1 = 3'($urandom); d1 = $urandom;
      end
      step(v0, w0, a0, d0, v1, w1, a1, d1, g0, g1, e0, e1, en);
      checks++; if (R0_RVALID !== g0 || R1_RVALID !== g1 || en !== (g0 | g1)) begin
        errors++;
        $display("FAIL rand_valid[%0d]: got v=%b%b en=%b want %b%b %b", n, R1_RVALID,
                 R0_RVALID, en, g1, g0, g0 | g1);
      end
      if (g0) begin
        checks++; if (R0_RDATA !== e0) begin errors++;
          $display("FAIL rand_r0_data[%0d]: got %h want %h", n, R0_RDATA, e0); end
      end
      if (g1) begin
        checks++; if (R1_RDATA !== e1) begin errors++;
          $display("FAIL rand_r1_data[%0d]: got %h want %h", n, R1_RDATA, e1); end
      end
      wait0 = (v0 && !g0) ? wait0 + 1 : 0;
      wait1 = (v1 && !g1) ? wait1 + 1 : 0;
      if (v0 || v1) begin
        checks++; if (wait0 > 1 || wait1 > 1) begin errors++;
          $display("FAIL rand_fair[%0d]: got waits %0d/%0d want <=1", n, wait0, wait1); end
      end
      if (g0) v0 = 1'b0;
      if (g1) v1 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_byte_lanes();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
